vga_msg_screen: RTL and testbench

- Parametrised VGA timing generator and end-of-game message renderer. It is the successor to the fixed 640x480 "WIN" screen.
- Draws a bordered frame and a centred, scaled text string chosen at run time (WIN / LOSE / DRAW / blank).
- Sits between the game FSM (`msg_sel`, `fg_color`) and the board VGA connector. Runs on the 25 MHz pixel clock.

---
 rtl/vga_msg_pkg.sv | 76 +++++++
 rtl/msg_font_rom.sv | 40 ++++
 rtl/vga_msg_screen.sv | 184 ++++++++++++++++++
 tb/tb_vga_msg_screen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_msg_pkg.sv
// Shared types for the end-of-game message screen: glyph codes, message
// selector values, the message-to-glyph lookup and default 640x480 timing.
package vga_msg_pkg;

  typedef enum logic [3:0] {
    G_SP, G_W, G_I, G_N, G_L, G_O, G_S, G_E, G_D, G_R, G_A
  } glyph_t;

  typedef enum logic [1:0] {
    MSG_WIN   = 2'd0,
    MSG_LOSE  = 2'd1,
    MSG_DRAW  = 2'd2,
    MSG_BLANK = 2'd3
  } msg_t;

  // Region flags that travel alongside each pixel through the pipeline.
  typedef struct packed {
    logic active;
    logic border;
    logic text;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  typedef struct packed {
    flags_t     flags;
    glyph_t     glyph;
    logic [2:0] row;
    logic [2:0] col;
  } pix_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Every string is four cells wide; short words are padded with spaces.
  function automatic glyph_t glyph_of(input msg_t msg, input logic [1:0] idx);
    glyph_t g;
    g = G_SP;
    case (msg)
      MSG_WIN: begin
        case (idx)
          2'd0:    g = G_W;
          2'd1:    g = G_I;
          2'd2:    g = G_N;
          default: g = G_SP;
        endcase
      end
      MSG_LOSE: begin
        case (idx)
          2'd0:    g = G_L;
          2'd1:    g = G_O;
          2'd2:    g = G_S;
          default: g = G_E;
        endcase
      end
      MSG_DRAW: begin
        case (idx)
          2'd0:    g = G_D;
          2'd1:    g = G_R;
          2'd2:    g = G_A;
          default: g = G_W;
        endcase
      end
      default: g = G_SP;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/msg_font_rom.sv
// Registered 8x8 glyph ROM; row 0 is the top line, bit 7 the leftmost pixel.
// Its output register forms the second pipeline stage of vga_msg_screen.
module msg_font_rom
  import vga_msg_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  glyph_t     glyph,
  input  logic [2:0] row,
  output logic [7:0] row_bits
);

  function automatic logic [63:0] glyph_bitmap(input glyph_t gl);
    logic [63:0] bm;
    case (gl)
      G_W:     bm = 64'hC6C6_C6D6_FEEE_C600;
      G_I:     bm = 64'h7E18_1818_1818_7E00;
      G_N:     bm = 64'hC6E6_F6DE_CEC6_C600;
      G_L:     bm = 64'hC0C0_C0C0_C0C0_FE00;
      G_O:     bm = 64'h7CC6_C6C6_C6C6_7C00;
      G_S:     bm = 64'h7CC6_C07C_06C6_7C00;
      G_E:     bm = 64'hFEC0_C0FC_C0C0_FE00;
      G_D:     bm = 64'hF8CC_C6C6_C6CC_F800;
      G_R:     bm = 64'hFCC6_C6FC_D8CC_C600;
      G_A:     bm = 64'h386C_C6C6_FEC6_C600;
      default: bm = 64'h0;
    endcase
    return bm;
  endfunction

  logic [63:0] bitmap;
  assign bitmap = glyph_bitmap(glyph);

  // NOTE: the table is constant logic; only the output register carries reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) row_bits <= '0;
    else        row_bits <= bitmap[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/vga_msg_screen.sv
// VGA timing generator drawing two border bars and a centred, scaled message.
// Define VGA_MSG_BLINK_EN to blink the text with a 64-frame period.
module vga_msg_screen
  import vga_msg_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
  parameter int unsigned H_FP          = DEF_H_FP,
  parameter int unsigned H_SYNC        = DEF_H_SYNC,
  parameter int unsigned H_BP          = DEF_H_BP,
  parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
  parameter int unsigned V_FP          = DEF_V_FP,
  parameter int unsigned V_SYNC        = DEF_V_SYNC,
  parameter int unsigned V_BP          = DEF_V_BP,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned SCALE         = 8,
  parameter int unsigned BORDER_W      = 10,
  parameter int unsigned BORDER_MARGIN = 80
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [1:0]  msg_sel,
  input  logic [11:0] fg_color,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        de,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HW      = $clog2(H_TOTAL);
  localparam int          VW      = $clog2(V_TOTAL);
  localparam int          SHIFT   = $clog2(SCALE);
  localparam int unsigned BOX_W   = 32 * SCALE;
  localparam int unsigned BOX_H   = 8 * SCALE;
  localparam int unsigned X0      = (H_ACTIVE - BOX_W) / 2;
  localparam int unsigned Y0      = (V_ACTIVE - BOX_H) / 2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] BL_BEG = HW'(BORDER_MARGIN);
  localparam logic [HW-1:0] BL_END = HW'(BORDER_MARGIN + BORDER_W);
  localparam logic [HW-1:0] BR_BEG = HW'(H_ACTIVE - BORDER_MARGIN - BORDER_W);
  localparam logic [HW-1:0] BR_END = HW'(H_ACTIVE - BORDER_MARGIN);
  localparam logic [HW-1:0] X0_C   = HW'(X0);
  localparam logic [HW-1:0] X1_C   = HW'(X0 + BOX_W);
  localparam logic [VW-1:0] Y0_C   = VW'(Y0);
  localparam logic [VW-1:0] Y1_C   = VW'(Y0 + BOX_H);

  if (BOX_W > H_ACTIVE || BOX_H > V_ACTIVE) begin : g_box_too_big
    $error("vga_msg_screen: text box larger than the active area");
  end
  if (SCALE < 1 || SCALE > 16 || (SCALE & (SCALE - 1)) != 0) begin : g_bad_scale
    $error("vga_msg_screen: SCALE must be a power of two in 1..16");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          frame_first;
  logic          frame_last;

  assign frame_first = (hcnt == '0) && (vcnt == '0);
  assign frame_last  = (hcnt == H_LAST) && (vcnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Inputs are captured only at pixel (0,0) so a frame never mixes two messages.
  msg_t        msg_lat;
  logic [11:0] fg_lat;
  msg_t        msg_cur;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      msg_lat <= MSG_BLANK;
      fg_lat  <= '0;
    end else if (frame_first) begin
      msg_lat <= msg_t'(msg_sel);
      fg_lat  <= fg_color;
    end
  end

  assign msg_cur = frame_first ? msg_t'(msg_sel) : msg_lat;

  logic text_on;
`ifdef VGA_MSG_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)          frame_cnt <= '0;
    else if (frame_last) frame_cnt <= frame_cnt + 6'd1;
  end
  assign text_on = ~frame_cnt[5];
`else
  assign text_on = 1'b1;
`endif

  // Cell coordinates inside the text box, in unscaled glyph units.
  logic [4:0] cell_x;
  logic [2:0] cell_y;
  assign cell_x = 5'((hcnt - X0_C) >> SHIFT);
  assign cell_y = 3'((vcnt - Y0_C) >> SHIFT);

  pix_t s1_d;
  pix_t s1_q;

  // NOTE: every field gets a default first so no path leaves a latch behind.
  always_comb begin
    s1_d              = '0;
    s1_d.flags.active = (hcnt < H_ACT) && (vcnt < V_ACT);
    s1_d.flags.border = s1_d.flags.active &&
                        (((hcnt >= BL_BEG) && (hcnt < BL_END)) ||
                         ((hcnt >= BR_BEG) && (hcnt < BR_END)));
    s1_d.flags.text   = s1_d.flags.active && text_on &&
                        (hcnt >= X0_C) && (hcnt < X1_C) &&
                        (vcnt >= Y0_C) && (vcnt < Y1_C);
    s1_d.flags.hs     = (hcnt >= HS_BEG) && (hcnt < HS_END);
    s1_d.flags.vs     = (vcnt >= VS_BEG) && (vcnt < VS_END);
    s1_d.flags.fs     = frame_first;
    s1_d.glyph        = glyph_of(msg_cur, cell_x[4:3]);
    s1_d.row          = cell_y;
    s1_d.col          = cell_x[2:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  logic [7:0] rom_bits;

  msg_font_rom u_font (
    .clk      (clk),
    .clr_n    (clr_n),
    .glyph    (s1_q.glyph),
    .row      (s1_q.row),
    .row_bits (rom_bits)
  );

  flags_t      s2_flags;
  logic [2:0]  s2_col;
  logic [11:0] s2_color;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s2_flags <= '0;
      s2_col   <= '0;
      s2_color <= '0;
    end else begin
      s2_flags <= s1_q.flags;
      s2_col   <= s1_q.col;
      s2_color <= s1_q.flags.border ? 12'hFFF : fg_lat;
    end
  end

  // Border wins over text; both flags are already gated by the active region.
  logic pix_on;
  assign pix_on = s2_flags.border || (s2_flags.text && rom_bits[~s2_col]);

  assign {r, g, b}   = pix_on ? s2_color : 12'h000;
  assign hsync       = s2_flags.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = s2_flags.vs ? SYNC_POL : ~SYNC_POL;
  assign de          = s2_flags.active;
  assign frame_start = s2_flags.fs;

endmodule

// File: tb/tb_vga_msg_screen.sv
// Scoreboard bench for vga_msg_screen on a reduced 128x40 raster: a pixel-level
// reference model queues expected outputs, a monitor pops and compares them.
module tb_vga_msg_screen;

  localparam int HA = 96, HF = 8, HSY = 12, HB = 12;
  localparam int VA = 32, VF = 3, VSY = 2, VB = 3;
  localparam int SC = 2, BW = 3, BM = 6;
  localparam int LINE  = HA + HF + HSY + HB;
  localparam int LINES = VA + VF + VSY + VB;
  localparam int FRAME = LINE * LINES;
  localparam int X0 = (HA - 32 * SC) / 2;
  localparam int Y0 = (VA - 8 * SC) / 2;

  logic        clk;
  logic        clr_n;
  logic [1:0]  msg_sel;
  logic [11:0] fg_color;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  r, g, b;

  vga_msg_screen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0), .SCALE(SC), .BORDER_W(BW), .BORDER_MARGIN(BM)
  ) dut (
    .clk(clk), .clr_n(clr_n), .msg_sel(msg_sel), .fg_color(fg_color),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .de(de), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int   x;
    int   y;
    out_t o;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 32'({hsync, vsync, de, frame_start, r, g, b}), 32'({4'b1100, 12'h000}));
  endtask

  function automatic string msg_text(input int m);
    case (m)
      0:       return "WIN ";
      1:       return "LOSE";
      2:       return "DRAW";
      default: return "    ";
    endcase
  endfunction

  function automatic logic [7:0] font_row(input byte ch, input int row);
    logic [63:0] bm;
    case (ch)
      "W":     bm = 64'hC6C6C6D6FEEEC600;
      "I":     bm = 64'h7E18181818187E00;
      "N":     bm = 64'hC6E6F6DECEC6C600;
      "L":     bm = 64'hC0C0C0C0C0C0FE00;
      "O":     bm = 64'h7CC6C6C6C6C67C00;
      "S":     bm = 64'h7CC6C07C06C67C00;
      "E":     bm = 64'hFEC0C0FCC0C0FE00;
      "D":     bm = 64'hF8CCC6C6C6CCF800;
      "R":     bm = 64'hFCC6C6FCD8CCC600;
      "A":     bm = 64'h386CC6C6FEC6C600;
      default: bm = 64'h0;
    endcase
    return bm[8 * (7 - row) +: 8];
  endfunction

  function automatic out_t expect_px(input int x, input int y, input int m,
                                     input logic [11:0] fg, input bit show);
    out_t       o;
    int         cx, cy;
    string      s;
    logic [7:0] bits;
    o    = '0;
    o.hs = !(x >= HA + HF && x < HA + HF + HSY);
    o.vs = !(y >= VA + VF && y < VA + VF + VSY);
    o.fs = (x == 0 && y == 0);
    if (x < HA && y < VA) begin
      o.de = 1'b1;
      if ((x >= BM && x < BM + BW) || (x >= HA - BM - BW && x < HA - BM)) begin
        o.rgb = 12'hFFF;
      end else if (show && x >= X0 && x < X0 + 32 * SC && y >= Y0 && y < Y0 + 8 * SC) begin
        cx   = (x - X0) / SC;
        cy   = (y - Y0) / SC;
        s    = msg_text(m);
        bits = font_row(s[cx / 8], cy);
        if (bits[7 - (cx % 8)]) o.rgb = fg;
      end
    end
    return o;
  endfunction

  // Reference model: raster position and latched message from the rules, one pixel per clock.
  int          mh, mv, mframe, lat_msg;
  logic [11:0] lat_fg;
  bit          show;
  item_t       new_it;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      exp_q.delete();
      mh = 0; mv = 0; mframe = 0; lat_msg = 3; lat_fg = '0;
    end else begin
      if (mh == 0 && mv == 0) begin
        lat_msg = int'(msg_sel);
        lat_fg  = fg_color;
      end
      show = 1'b1;
`ifdef VGA_MSG_BLINK_EN
      show = (mframe % 64) < 32;
`endif
      new_it.x = mh;
      new_it.y = mv;
      new_it.o = expect_px(mh, mv, lat_msg, lat_fg, show);
      exp_q.push_back(new_it);
      mh++;
      if (mh == LINE) begin
        mh = 0;
        mv++;
        if (mv == LINES) begin
          mv = 0;
          mframe++;
        end
      end
    end
  end

  // Monitor: outputs trail the model by two clocks.
  item_t cur;
  out_t  act;
  int    gap, border_cnt, fs_seen, fs_exp;
  bit    have_prev, frame_full;

  initial begin
    fs_seen = 0;
    fs_exp  = 0;
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      have_prev = 1'b0; frame_full = 1'b0; gap = 0; border_cnt = 0;
    end else begin
      gap++;
      if (frame_start) begin
        if (have_prev) check("frame_period", gap, FRAME);
        have_prev = 1'b1;
        gap       = 0;
        fs_seen++;
      end
      if (exp_q.size() >= 2) begin
        cur = exp_q.pop_front();
        if (cur.o.fs) begin
          fs_exp++;
          if (frame_full) check("border_count", border_cnt, 2 * BW * VA);
          frame_full = 1'b1;
          border_cnt = 0;
        end
        act = {hsync, vsync, de, frame_start, r, g, b};
        check($sformatf("pix(%0d,%0d)", cur.x, cur.y), 32'(act), 32'(cur.o));
        if (de && {r, g, b} == 12'hFFF) border_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic random_inputs();
    msg_sel  = 2'($urandom_range(0, 3));
    fg_color = 12'($urandom_range(0, 12'hFFE));
  endtask

  int budget, w;

  initial begin
    clr_n    = 1'b0;
    msg_sel  = 2'd0;
    fg_color = 12'hF00;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset_hold");
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1 check("fs_edge1", 32'(frame_start), 32'd0);
    @(posedge clk);
    #1 check("fs_edge2", 32'(frame_start), 32'd1);

    // Mid-frame change: frame 0 keeps WIN in red, frame 1 shows LOSE in green.
    repeat (20 * LINE) @(posedge clk);
    #2 msg_sel = 2'd1; fg_color = 12'h0F0;
    repeat (FRAME) @(posedge clk);
    #2 msg_sel = 2'd2; fg_color = 12'($urandom_range(0, 12'hFFE));
    repeat (FRAME) @(posedge clk);
    #2 msg_sel = 2'd3; fg_color = 12'($urandom_range(0, 12'hFFE));
    repeat (FRAME) @(posedge clk);

    budget = 2 * FRAME;
    while (budget > 0) begin
      w = int'($urandom_range(50, 900));
      repeat (w) @(posedge clk);
      #2 random_inputs();
      budget -= w;
    end

    // Asynchronous reset pulse somewhere mid-line.
    repeat ($urandom_range(10, 60)) @(posedge clk);
    #3 clr_n = 1'b0;
    #1 check_reset_outs("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1 check_reset_outs("reset_held");
    end
    random_inputs();
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1 check("fs_rst_edge1", 32'(frame_start), 32'd0);
    @(posedge clk);
    #1 check("fs_rst_edge2", 32'(frame_start), 32'd1);

    repeat (FRAME / 2) @(posedge clk);
    #2 random_inputs();
    repeat (FRAME / 2 + 20) @(posedge clk);
    #2;
    check("frame_starts", fs_seen, fs_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
